// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared types and helpers for the dBus memory responder.
//   state_e        : responder FSM states (IDLE accepts commands, READ streams
//                    a multi-beat read response).
//   burst_t        : decoded burst length plus an illegal-size flag.
//   beats_for_size : maps cmd size (log2 bytes) to the response beat count.
// -----------------------------------------------------------------------------
package dbus_pkg;

  localparam int DBUS_DATA_W = 32;
  localparam int DBUS_MASK_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  typedef struct packed {
    logic       illegal;
    logic [3:0] beats;
  } burst_t;

  // Sizes up to one word answer with a single beat; 8/16/32-byte accesses
  // become 2/4/8-beat bursts. Sizes 6 and 7 are flagged illegal and answered
  // with one error beat.
  function automatic burst_t beats_for_size(input logic [2:0] size);
    burst_t b;
    b.illegal = 1'b0;
    b.beats   = 4'd1;
    case (size)
      3'd3:       b.beats   = 4'd2;
      3'd4:       b.beats   = 4'd4;
      3'd5:       b.beats   = 4'd8;
      3'd6, 3'd7: b.illegal = 1'b1;
      default:    b.beats   = 4'd1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dbus_mem_array.sv
// -----------------------------------------------------------------------------
// dbus_mem_array
// Single-port 32-bit word RAM with per-byte write enables and a combinational
// read port. One address serves both the write and the read.
// Ports:
//   clk      : clock
//   i_we     : write enable (the whole word slot)
//   i_be     : byte enables, bit i governs data[8*i +: 8]
//   i_addr   : word address
//   i_wdata  : write data
//   o_rdata  : combinational read data at i_addr
// -----------------------------------------------------------------------------
module dbus_mem_array
  import dbus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [DBUS_MASK_W-1:0] i_be,
  input  logic [AW-1:0]          i_addr,
  input  logic [DBUS_DATA_W-1:0] i_wdata,
  output logic [DBUS_DATA_W-1:0] o_rdata
);

  logic [DBUS_DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; contents must survive a reset of the
  // responder, and a reset loop over every word would not map onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DBUS_MASK_W; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dbus_mem_responder.sv
// -----------------------------------------------------------------------------
// dbus_mem_responder
// Memory model answering the VexRiscv data bus from the driver side.
// Writes are applied byte-masked in one cycle with no response; reads return
// 1/2/4/8 registered beats, the first one the cycle after the accept.
// Accesses below BASE_ADDR or past MEM_WORDS words answer error=1, data=0;
// out-of-range writes are dropped.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_payload_wr        : 1 = write, 0 = read
//   cmd_payload_uncached  : accepted but does not change behaviour
//   cmd_payload_address   : byte address
//   cmd_payload_data/mask : write data and byte enables
//   cmd_payload_size      : log2 of the access size in bytes
//   cmd_payload_last      : write-burst marker, not needed here
//   rsp_valid             : response beat valid (no back-pressure)
//   rsp_payload_last/data/error : response beat contents
// Build option:
//   DBUS_RESP_STALL_EN    : when defined, a 16-bit Galois LFSR inserts random
//                           cmd_ready drops and withheld read beats.
// -----------------------------------------------------------------------------
module dbus_mem_responder
  import dbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_payload_wr,
  input  logic                   cmd_payload_uncached,
  input  logic [31:0]            cmd_payload_address,
  input  logic [DBUS_DATA_W-1:0] cmd_payload_data,
  input  logic [DBUS_MASK_W-1:0] cmd_payload_mask,
  input  logic [2:0]             cmd_payload_size,
  input  logic                   cmd_payload_last,
  output logic                   rsp_valid,
  output logic                   rsp_payload_last,
  output logic [DBUS_DATA_W-1:0] rsp_payload_data,
  output logic                   rsp_payload_error
);

  localparam int          AW          = $clog2(MEM_WORDS);
  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  state_e                 r_state, w_state_n;
  logic                   r_alive;
  logic [29:0]            r_word;
  logic [3:0]             r_left;
  logic                   r_below;
  logic                   r_rsp_valid, r_rsp_last, r_rsp_error;
  logic [DBUS_DATA_W-1:0] r_rsp_data;

  logic [31:0]            w_diff;
  logic                   w_below;
  logic [29:0]            w_idx, w_start;
  burst_t                 w_burst;
  logic                   w_stall_cmd, w_stall_rsp;
  logic                   w_cmd_ready, w_accept, w_we;
  logic                   w_fire, w_fire_last, w_fire_err;
  logic [AW-1:0]          w_mem_idx;
  logic [DBUS_DATA_W-1:0] w_rdata;

  // Range check works on the full 30-bit word index; only the RAM address is
  // truncated, so addresses that would alias into the array are still caught.
  assign w_diff  = cmd_payload_address - BASE_ADDR;
  assign w_below = cmd_payload_address < BASE_ADDR;
  assign w_idx   = w_diff[31:2];
  assign w_burst = beats_for_size(cmd_payload_size);
  assign w_start = w_idx & ~(30'(w_burst.beats) - 30'd1);

`ifdef DBUS_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic        w_unused_bits;

  // Galois form, taps 16,14,13,11 -> feedback mask 0xB400 on a right shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign w_stall_cmd   = (r_lfsr[1:0] == 2'b00);
  assign w_stall_rsp   = (r_lfsr[3:2] == 2'b00);
  assign w_unused_bits = ^{cmd_payload_uncached, cmd_payload_last, w_diff[1:0]};
`else
  logic w_unused_bits;

  assign w_stall_cmd   = 1'b0;
  assign w_stall_rsp   = 1'b0;
  assign w_unused_bits = ^{cmd_payload_uncached, cmd_payload_last, w_diff[1:0], LFSR_SEED};
`endif

  // r_alive keeps cmd_ready low until the first edge after reset release.
  assign w_cmd_ready = r_alive & (r_state == IDLE) & ~w_stall_cmd;
  assign w_accept    = cmd_valid & w_cmd_ready;
  assign w_we        = w_accept & cmd_payload_wr & ~w_below & (w_idx < MEM_WORDS_W);

  // Writes only happen in IDLE, and in IDLE the accepted command owns the
  // port, so a single RAM address is enough.
  assign w_mem_idx = (r_state == READ) ? r_word[AW-1:0]
                   : (cmd_payload_wr   ? w_idx[AW-1:0] : w_start[AW-1:0]);

  dbus_mem_array #(
    .DEPTH (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (cmd_payload_mask),
    .i_addr  (w_mem_idx),
    .i_wdata (cmd_payload_data),
    .o_rdata (w_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // Beat 0 is produced on the accept edge itself; READ only covers beats
  // 1..N-1, so single-beat reads never leave IDLE and cmd_ready is back high
  // in the same cycle as the last beat.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    w_state_n   = r_state;
    w_fire      = 1'b0;
    w_fire_last = 1'b0;
    w_fire_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && !cmd_payload_wr) begin
          w_fire      = 1'b1;
          w_fire_last = (w_burst.beats == 4'd1);
          w_fire_err  = w_burst.illegal | w_below | (w_start >= MEM_WORDS_W);
          if (!w_fire_last) w_state_n = READ;
        end
      end
      READ: begin
        if (!w_stall_rsp) begin
          w_fire      = 1'b1;
          w_fire_last = (r_left == 4'd1);
          w_fire_err  = r_below | (r_word >= MEM_WORDS_W);
          if (w_fire_last) w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alive     <= 1'b0;
      r_word      <= '0;
      r_left      <= '0;
      r_below     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_alive     <= 1'b1;
      r_rsp_valid <= w_fire;
      r_rsp_last  <= w_fire_last;
      r_rsp_error <= w_fire_err;
      r_rsp_data  <= (w_fire && !w_fire_err) ? w_rdata : '0;
      if (r_state == IDLE && w_fire) begin
        r_word  <= w_start + 30'd1;
        r_left  <= w_burst.beats - 4'd1;
        r_below <= w_below;
      end else if (r_state == READ && w_fire) begin
        r_word  <= r_word + 30'd1;
        r_left  <= r_left - 4'd1;
      end
    end
  end

  assign cmd_ready         = w_cmd_ready;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_payload_last  = r_rsp_last;
  assign rsp_payload_data  = r_rsp_data;
  assign rsp_payload_error = r_rsp_error;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dbus_mem_responder
// Self-checking bench for dbus_mem_responder: reset values, a directed vector
// table, an 8-beat burst, range boundaries, reset during a burst, and random
// traffic compared with a word-array reference model.
// -----------------------------------------------------------------------------
module tb_dbus_mem_responder;

  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_payload_wr;
  logic        cmd_payload_uncached;
  logic [31:0] cmd_payload_address;
  logic [31:0] cmd_payload_data;
  logic [3:0]  cmd_payload_mask;
  logic [2:0]  cmd_payload_size;
  logic        cmd_payload_last;
  logic        rsp_valid;
  logic        rsp_payload_last;
  logic [31:0] rsp_payload_data;
  logic        rsp_payload_error;

  always #5 clk = ~clk;

  dbus_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_payload_wr       (cmd_payload_wr),
    .cmd_payload_uncached (cmd_payload_uncached),
    .cmd_payload_address  (cmd_payload_address),
    .cmd_payload_data     (cmd_payload_data),
    .cmd_payload_mask     (cmd_payload_mask),
    .cmd_payload_size     (cmd_payload_size),
    .cmd_payload_last     (cmd_payload_last),
    .rsp_valid            (rsp_valid),
    .rsp_payload_last     (rsp_payload_last),
    .rsp_payload_data     (rsp_payload_data),
    .rsp_payload_error    (rsp_payload_error)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model: plain word array plus the addressing rules.
  logic [31:0] model_mem [MEM_WORDS];

  // Observed beats of the last read, and the model's expectation.
  logic [31:0] q_data[$];
  logic        q_err[$];
  logic        q_last[$];
  logic        q_rdy[$];
  int          q_cyc[$];
  logic [31:0] e_data[$];
  logic        e_err[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [2:0]  size;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_beats;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic [2:0] size);
    int tries;
    tries = 0;
    @(negedge clk);
    cmd_valid            = 1'b1;
    cmd_payload_wr       = wr;
    cmd_payload_uncached = $urandom_range(0, 1) == 1;
    cmd_payload_address  = addr;
    cmd_payload_data     = data;
    cmd_payload_mask     = mask;
    cmd_payload_size     = size;
    cmd_payload_last     = 1'b1;
    while (!cmd_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_op(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] idx;
    send_cmd(1'b1, addr, data, mask, 3'd2);
    idx = (addr - BASE) >> 2;
    if (addr >= BASE && idx < MEM_WORDS) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  // Issue a read and collect beats until last, bounded by a cycle budget.
  // Cycle 0 is the sample taken 1 ns after the accept edge.
  task automatic read_op(input logic [31:0] addr, input logic [2:0] size);
    bit done;
    done = 1'b0;
    q_data.delete(); q_err.delete(); q_last.delete(); q_rdy.delete(); q_cyc.delete();
    send_cmd(1'b0, addr, 32'h0, 4'h0, size);
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) begin
        q_data.push_back(rsp_payload_data);
        q_err.push_back(rsp_payload_error);
        q_last.push_back(rsp_payload_last);
        q_rdy.push_back(cmd_ready);
        q_cyc.push_back(c);
        if (rsp_payload_last) begin
          done = 1'b1;
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL read_timeout addr %h: got no last beat, expected one within 40 cycles", addr);
    end
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [2:0] size);
    int              sz, n;
    logic [31:0]     diff;
    longint unsigned idx, start, w;
    bit              bad;
    e_data.delete(); e_err.delete();
    sz    = int'(size);
    n     = (sz >= 3 && sz <= 5) ? (1 << (sz - 2)) : 1;
    diff  = addr - BASE;
    idx   = longint'(diff >> 2);
    start = idx - (idx % longint'(n));
    for (int k = 0; k < n; k++) begin
      w   = start + longint'(k);
      bad = (sz > 5) || (addr < BASE) || (w >= MEM_WORDS);
      e_err.push_back(bad);
      e_data.push_back(bad ? 32'h0 : model_mem[w]);
    end
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr, input logic [2:0] size);
    int n;
    model_read(addr, size);
    read_op(addr, size);
    check($sformatf("%s beats", tag), q_data.size(), e_data.size());
    n = (q_data.size() < e_data.size()) ? q_data.size() : e_data.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s data[%0d]", tag, k), q_data[k], e_data[k]);
      check($sformatf("%s err[%0d]", tag, k), {31'b0, q_err[k]}, {31'b0, e_err[k]});
      check($sformatf("%s last[%0d]", tag, k), {31'b0, q_last[k]}, (k == e_data.size() - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s ready[%0d]", tag, k), {31'b0, q_rdy[k]}, (k == e_data.size() - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s cycle[%0d]", tag, k), q_cyc[k], k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    logic [31:0] a;
    int          r;

    reset                = 1'b0;
    cmd_valid            = 1'b0;
    cmd_payload_wr       = 1'b0;
    cmd_payload_uncached = 1'b0;
    cmd_payload_address  = 32'h0;
    cmd_payload_data     = 32'h0;
    cmd_payload_mask     = 4'h0;
    cmd_payload_size     = 3'd0;
    cmd_payload_last     = 1'b0;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst rsp_last", {31'b0, rsp_payload_last}, 32'd0);
    check("rst rsp_data", rsp_payload_data, 32'd0);
    check("rst rsp_error", {31'b0, rsp_payload_error}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("post_rst rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // ---------------- directed vector table ----------------
    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 32'h0,         1'b0, 0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 3'd2, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 3'd2, 32'h0,         1'b0, 0};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 3'd2, 32'hDE22_BE44, 1'b0, 1};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 3'd2, 32'h0,         1'b0, 0};
    vecs[5]  = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 3'd2, 32'h0,         1'b0, 0};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 3'd0, 32'h0BAD_F00D, 1'b0, 1};
    vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 3'd2, 32'h0,         1'b1, 1};
    vecs[8]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 3'd2, 32'h0,         1'b1, 1};
    vecs[9]  = '{1'b1, 32'h8000_0014, 32'h5566_7788, 4'hF, 3'd2, 32'h0,         1'b0, 0};
    vecs[10] = '{1'b0, 32'h8000_0014, 32'h0,         4'h0, 3'd3, 32'hDE22_BE44, 1'b0, 2};
    vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 3'd6, 32'h0,         1'b1, 1};
    vecs[12] = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 3'd2, 32'h0,         1'b0, 0};
    vecs[13] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 3'd1, 32'hCAFE_F00D, 1'b0, 1};
    vecs[14] = '{1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 3'd2, 32'h0,         1'b0, 0};
    vecs[15] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 3'd2, 32'hCAFE_F00D, 1'b0, 1};
    vecs[16] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 3'd7, 32'h0,         1'b1, 1};

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        write_op(vecs[i].addr, vecs[i].data, vecs[i].mask);
      end else begin
        read_op(vecs[i].addr, vecs[i].size);
        check($sformatf("vec[%0d] beats", i), q_data.size(), vecs[i].exp_beats);
        if (q_data.size() > 0) begin
          check($sformatf("vec[%0d] data", i), q_data[0], vecs[i].exp_data);
          check($sformatf("vec[%0d] err", i), {31'b0, q_err[0]}, {31'b0, vecs[i].exp_err});
          check($sformatf("vec[%0d] latency", i), q_cyc[0], 0);
          check($sformatf("vec[%0d] last", i), {31'b0, q_last[q_last.size() - 1]}, 32'd1);
        end
      end
    end

    // ---------------- preload, back-to-back writes ----------------
    c0 = cyc_cnt;
    for (int w = 0; w < MEM_WORDS; w++)
      write_op(BASE + 32'(4 * w), (w >= 8 && w < 16) ? 32'(w) : $urandom, 4'hF);
    check("preload one write per cycle", cyc_cnt - c0, MEM_WORDS);

    // ---------------- bursts and boundaries ----------------
    check_read("burst8", BASE + 32'h24, 3'd5);
    for (int k = 0; k < 8 && k < q_data.size(); k++)
      check($sformatf("burst8 word[%0d]", k), q_data[k], 32'(8 + k));
    check_read("below_burst", 32'h7FFF_FFE0, 3'd5);
    check_read("top_burst", BASE + 32'(4 * (MEM_WORDS - 3)), 3'd4);
    check_read("size3_odd", BASE + 32'(4 * 13 + 2), 3'd3);
    check_read("last_word", BASE + 32'(4 * (MEM_WORDS - 1)), 3'd2);
    check_read("past_end", BASE + 32'(4 * MEM_WORDS), 3'd2);

    // ---------------- reset in the middle of a burst ----------------
    send_cmd(1'b0, BASE + 32'h20, 32'h0, 4'h0, 3'd5);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_burst beat3 data", rsp_payload_data, 32'd11);
    #1 reset = 1'b0;
    #1;
    check("mid_reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_reset cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("mid_reset rsp_data", rsp_payload_data, 32'd0);
    @(posedge clk);
    #1;
    check("held_reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("after_reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_read("after_reset burst", BASE + 32'h24, 3'd5);

    // ---------------- random traffic against the model ----------------
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)
        a = BASE - 32'(4 * $urandom_range(1, 16));
      else if (r < 20)
        a = BASE + 32'(4 * MEM_WORDS) + 32'(4 * $urandom_range(0, 16));
      else
        a = BASE + 32'(4 * $urandom_range(0, MEM_WORDS - 1)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        write_op(a, $urandom, 4'($urandom));
      else
        check_read($sformatf("rnd%0d", i), a, 3'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Memory-model responder for the VexRiscv data bus. It sits on the driver side of the dBus interface and answers the CPU's data-cache and uncached traffic.
- Accepts cmd beats, applies byte-masked writes to an internal word array, and returns read data as 1–8-beat bursts with last and error flags.
- Used as the backing memory in CPU-level testbenches and simple SoC sims.

Parameters:
- MEM_WORDS, 1024: depth of the 32-bit word array (power of two).
- BASE_ADDR, 32'h8000_0000: byte address mapped to word 0.
- LFSR_SEED, 16'hACE1: seed for the stall LFSR (used only with the optional feature).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command valid
- cmd_ready  output  1  responder can accept a command
- cmd_payload_wr  input  1  1 = write, 0 = read
- cmd_payload_uncached  input  1  uncached access (behaviour identical; recorded only)
- cmd_payload_address  input  32  byte address
- cmd_payload_data  input  32  write data
- cmd_payload_mask  input  4  byte-enable for writes
- cmd_payload_size  input  3  log2 of access size in bytes
- cmd_payload_last  input  1  last beat of a write burst
- rsp_valid  output  1  response beat valid (no ready; the CPU always accepts)
- rsp_payload_last  output  1  final beat of the read response
- rsp_payload_data  output  32  read data
- rsp_payload_error  output  1  access error

Behaviour:
- Reset (reset=0, asynchronous):
  - cmd_ready=0, rsp_valid=0, rsp_payload_last=0, rsp_payload_data=0, rsp_payload_error=0.
  - FSM returns to IDLE; beat counter is 0.
  - Memory contents are not cleared.
  - Reset asserted mid-burst aborts the burst; no further beats are emitted.
- FSM states: IDLE and READ.
  - IDLE: cmd_ready=1, from the first cycle after reset release.
  - READ: cmd_ready=0.
- Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready.
- Write accept (wr=1):
  - Word index = (address-BASE_ADDR)>>2.
  - Bytes with mask[i]=1 are updated on the same edge; size is ignored (the mask governs).
  - Stay in IDLE; no response is generated.
  - Back-to-back writes sustain 1 per cycle; cmd_payload_last is ignored.
- Read accept (wr=0):
  - Beats = 1 for size 0..2; 2/4/8 for size 3/4/5.
  - Start word = index aligned down to the beat count; the sequence is linear, no wrap.
  - Enter READ. The first rsp beat is registered and appears the cycle after accept, then one beat per cycle.
  - rsp_payload_last=1 on the final beat only.
  - After the last beat, return to IDLE; cmd_ready=1 in that same cycle as last.
- Out-of-range access:
  - Any beat whose word index is >= MEM_WORDS, or whose address is below BASE_ADDR, returns rsp_payload_error=1 with data 0. The beat count is unchanged.
  - Out-of-range writes are dropped silently.
- Illegal size (6 or 7) on a read: single beat with error=1, last=1.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1.
- Arithmetic:
  - Subtraction is 32-bit unsigned.
  - The range check uses the full difference before truncating to $clog2(MEM_WORDS) bits.

Optional Feature:
- Macro DBUS_RESP_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed LFSR_SEED) advances every cycle.
  - In IDLE, cmd_ready is forced to 0 when lfsr[1:0]==2'b00.
  - In READ, a beat is withheld (rsp_valid=0, counter held) when lfsr[3:2]==2'b00.
  - Beat order and last/error semantics are unchanged.
- Undefined: no LFSR logic; timing exactly as above.

Decomposition:
- Package dbus_pkg holds:
  - state_e {IDLE, READ}
  - DBUS_DATA_W=32 and DBUS_MASK_W=4
  - function beats_for_size(size) returning 4-bit count plus an illegal flag
- Sub-module dbus_mem_array: single-port word RAM with a 4-bit byte-enable write and combinational read. The FSM, counter, range check and LFSR stay in the top.

Test Plan:
- Release reset → cmd_ready=0, rsp_valid=0 during reset; cmd_ready=1 the first cycle after.
- Write 0x8000_0010 data 0xDEADBEEF mask 4'hF, then read size 2 → one beat 0xDEADBEEF, last=1, error=0, one cycle after accept.
- Write mask 4'b0101 data 0x11223344 over 0xDEADBEEF, then read → 0xDE22BE44.
- Preload words 8..15 with i, then read 0x8000_0024 size 5 → 8 beats 8..15 on consecutive cycles; last on beat 8; cmd_ready=0 throughout, 1 with last.
- Read 0x7FFF_FFFC, and read BASE_ADDR+4*MEM_WORDS → error=1, data=0, last=1. Write to out-of-range, then read in range → memory unchanged.
- Assert reset after beat 3 of an 8-beat burst → rsp_valid=0 immediately. After release, a new read returns correct data.
